uart_rx_cfg: RTL and testbench

- Next-generation UART receiver, successor to the fixed-format 8-bit receiver.
- Adds a built-in baud-tick divider, parametrised oversampling, and run-time frame format (5–8 data bits; none/even/odd parity; 1 or 2 stop bits).
- Adds framing-error and break detection, plus an RX FIFO with a valid/ready read port and a sticky overrun flag.
- Sits between the pad-side rxd and the register/bus interface of the UART.

---
 rtl/uart_pkg.sv | 43 ++++
 rtl/uart_sync_fifo.sv | 69 ++++++
 rtl/uart_rx_cfg.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: FSM encoding,
// frame-format constants and the RX FIFO entry layout.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    localparam int RX_ENTRY_W = 11;

    typedef struct packed {
        logic       brk;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;

    // Index of the final data bit for a data_bits code.
    function automatic logic [2:0] last_bit_idx(input logic [1:0] data_bits);
        case (data_bits)
            DBITS_5: return 3'd4;
            DBITS_6: return 3'd5;
            DBITS_7: return 3'd6;
            DBITS_8: return 3'd7;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with flush, fill level and a head that reads zero when
// empty. Shared by the RX and TX paths of the UART.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     drop,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full, do_push, do_pop;

    assign full      = (level_q == (AW+1)'(DEPTH));
    assign out_valid = (level_q != '0);
    assign do_pop    = out_valid && pop;
    assign do_push   = push && !flush && (!full || do_pop);
    assign drop      = push && !flush && full && !do_pop;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign level     = level_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is not reset; out_data is masked while empty so stale contents never show.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with baud divider, oversampled majority vote, run-time frame
// format, framing/break detection and an RX FIFO with sticky overrun.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int OVS        = 16,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_en,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic [1:0]                    data_bits,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop_bits,
    input  logic                          rxd,
    input  logic                          m_ready,
    input  logic                          flush,
    input  logic                          clr_ovr,
    output logic                          m_valid,
    output logic [7:0]                    m_data,
    output logic                          m_perr,
    output logic                          m_ferr,
    output logic                          m_brk,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
    output logic                          busy
);

    localparam int SW = $clog2(OVS);
    localparam logic [SW-1:0] S_V0  = SW'(OVS/2 - 1);
    localparam logic [SW-1:0] S_V1  = SW'(OVS/2);
    localparam logic [SW-1:0] S_DEC = SW'(OVS/2 + 1);
    localparam logic [SW-1:0] S_END = SW'(OVS - 1);

    logic             rx_meta_q, rxs_q;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d, div_lim_q, div_lim_d;
    logic             tick;
    rx_state_e        state_q, state_d;
    logic [SW-1:0]    s_cnt_q, s_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             stop_idx_q, stop_idx_d;
    logic [1:0]       samp_q, samp_d;
    logic [7:0]       data_q, data_d;
    logic             perr_q, perr_d, ferr_q, ferr_d, par_bit_q, par_bit_d;
    logic [2:0]       cfg_last_q, cfg_last_d;
    logic [1:0]       cfg_par_q, cfg_par_d;
    logic             cfg_stop_q, cfg_stop_d;
    logic             overrun_q, overrun_d;
    logic             vote, par_en, par_exp, ferr_now;
    logic             push, fifo_drop;
    rx_entry_t        push_entry, head;

    // Divider limit is reloaded only at wrap, so baud_div edits land cleanly.
    always_comb begin
        tick      = 1'b0;
        div_cnt_d = div_cnt_q;
        div_lim_d = div_lim_q;
        if (!rx_en) begin
            div_cnt_d = '0;
            div_lim_d = baud_div;
        end else if (div_cnt_q == div_lim_q) begin
            tick      = 1'b1;
            div_cnt_d = '0;
            div_lim_d = baud_div;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
    assign par_en   = (cfg_par_q == PAR_EVEN) || (cfg_par_q == PAR_ODD);
    assign par_exp  = (^data_q) ^ (cfg_par_q == PAR_ODD);
    assign ferr_now = ferr_q | ~vote;

    always_comb begin
        state_d    = state_q;
        s_cnt_d    = s_cnt_q;
        idx_d      = idx_q;
        stop_idx_d = stop_idx_q;
        samp_d     = samp_q;
        data_d     = data_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        par_bit_d  = par_bit_q;
        cfg_last_d = cfg_last_q;
        cfg_par_d  = cfg_par_q;
        cfg_stop_d = cfg_stop_q;
        push       = 1'b0;
        push_entry = '0;

        if (tick) begin
            if (state_q != IDLE && state_q != WAIT_HIGH) begin
                s_cnt_d = (s_cnt_q == S_END) ? '0 : s_cnt_q + 1'b1;
                if (s_cnt_q == S_V0) samp_d[0] = rxs_q;
                if (s_cnt_q == S_V1) samp_d[1] = rxs_q;
            end

            case (state_q)
                IDLE: begin
                    if (!rxs_q) begin
                        cfg_last_d = last_bit_idx(data_bits);
                        cfg_par_d  = parity_mode;
                        cfg_stop_d = stop_bits;
                        s_cnt_d    = '0;
                        idx_d      = '0;
                        stop_idx_d = 1'b0;
                        data_d     = '0;
                        perr_d     = 1'b0;
                        ferr_d     = 1'b0;
                        par_bit_d  = 1'b0;
                        state_d    = START;
                    end
                end
                START: begin
                    if (s_cnt_q == S_DEC && vote) begin
                        state_d = IDLE;
                        s_cnt_d = '0;
                    end else if (s_cnt_q == S_END) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
                DATA: begin
                    if (s_cnt_q == S_DEC) data_d[idx_q] = vote;
                    if (s_cnt_q == S_END) begin
                        if (idx_q == cfg_last_q) state_d = par_en ? PARITY : STOP;
                        else                     idx_d   = idx_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (s_cnt_q == S_DEC) begin
                        par_bit_d = vote;
                        perr_d    = vote ^ par_exp;
                    end
                    if (s_cnt_q == S_END) state_d = STOP;
                end
                STOP: begin
                    // Push at the decision point of the last stop bit so a
                    // back-to-back start bit is not missed.
                    if (s_cnt_q == S_DEC) begin
                        ferr_d = ferr_now;
                        if (stop_idx_q == cfg_stop_q) begin
                            push            = 1'b1;
                            push_entry.data = data_q;
                            push_entry.perr = perr_q;
                            push_entry.ferr = ferr_now;
                            push_entry.brk  = ferr_now && (data_q == '0) && (!par_en || !par_bit_q);
                            state_d         = ferr_now ? WAIT_HIGH : IDLE;
                            s_cnt_d         = '0;
                        end
                    end
                    if (s_cnt_q == S_END) stop_idx_d = 1'b1;
                end
                WAIT_HIGH: begin
                    if (rxs_q) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        if (!rx_en) begin
            state_d    = IDLE;
            s_cnt_d    = '0;
            idx_d      = '0;
            stop_idx_d = 1'b0;
            push       = 1'b0;
        end
    end

    assign overrun_d = fifo_drop | (overrun_q & ~clr_ovr);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            div_cnt_q  <= '0;
            div_lim_q  <= '0;
            state_q    <= IDLE;
            s_cnt_q    <= '0;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            samp_q     <= '0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            par_bit_q  <= 1'b0;
            cfg_last_q <= 3'd7;
            cfg_par_q  <= PAR_NONE;
            cfg_stop_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rxd;
            rxs_q      <= rx_meta_q;
            div_cnt_q  <= div_cnt_d;
            div_lim_q  <= div_lim_d;
            state_q    <= state_d;
            s_cnt_q    <= s_cnt_d;
            idx_q      <= idx_d;
            stop_idx_q <= stop_idx_d;
            samp_q     <= samp_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            par_bit_q  <= par_bit_d;
            cfg_last_q <= cfg_last_d;
            cfg_par_q  <= cfg_par_d;
            cfg_stop_q <= cfg_stop_d;
            overrun_q  <= overrun_d;
        end
    end

    uart_sync_fifo #(
        .WIDTH (RX_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (m_ready),
        .flush     (flush),
        .out_valid (m_valid),
        .out_data  (head),
        .drop      (fifo_drop),
        .level     (fifo_level)
    );

    assign m_data  = head.data;
    assign m_perr  = head.perr;
    assign m_ferr  = head.ferr;
    assign m_brk   = head.brk;
    assign overrun = overrun_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed self-checking bench for uart_rx_cfg: frame formats, errors,
// break, glitch rejection, majority vote, enable abort and FIFO boundaries.
module tb_uart_rx_cfg;

    localparam int BIT_CYC = 64;

    logic       clk = 1'b0;
    logic       rst, rx_en, stop_bits, rxd, m_ready, flush, clr_ovr;
    logic [15:0] baud_div;
    logic [1:0] data_bits, parity_mode;
    logic       m_valid, m_perr, m_ferr, m_brk, overrun, busy;
    logic [7:0] m_data;
    logic [3:0] fifo_level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.OVS(16), .DIV_W(16), .FIFO_DEPTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_en       (rx_en),
        .baud_div    (baud_div),
        .data_bits   (data_bits),
        .parity_mode (parity_mode),
        .stop_bits   (stop_bits),
        .rxd         (rxd),
        .m_ready     (m_ready),
        .flush       (flush),
        .clr_ovr     (clr_ovr),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_perr      (m_perr),
        .m_ferr      (m_ferr),
        .m_brk       (m_brk),
        .fifo_level  (fifo_level),
        .overrun     (overrun),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One bit period; with glitch set, a one-tick pulse of the opposite
    // level lands on the middle vote sample.
    task automatic drive_bit(input logic v, input bit glitch);
        for (int c = 0; c < BIT_CYC; c++) begin
            @(negedge clk);
            rxd = (glitch && c >= 36 && c < 40) ? ~v : v;
        end
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                              input logic par_b, input logic stop0, input bit two_stop,
                              input bit glitch);
        logic [7:0] dv;
        dv = d;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(dv[i], glitch);
        if (par_en) drive_bit(par_b, 1'b0);
        drive_bit(stop0, 1'b0);
        if (two_stop) drive_bit(1'b1, 1'b0);
    endtask

    task automatic set_fmt(input logic [1:0] db, input logic [1:0] pm, input logic sb);
        data_bits   = db;
        parity_mode = pm;
        stop_bits   = sb;
    endtask

    // Checks the head as {valid, brk, ferr, perr, data}, then pops it.
    task automatic pop_check(input string tag, input logic [7:0] d, input logic perr,
                             input logic ferr, input logic brk);
        @(negedge clk);
        chk(tag, {m_valid, m_brk, m_ferr, m_perr, m_data}, {1'b1, brk, ferr, perr, d});
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic wait_not_busy(input string tag);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy, 1'b0);
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    logic [7:0] ovr_vals [9] = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67, 8'h78, 8'h89};

    initial begin
        #600us;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        rst = 1'b1; rx_en = 1'b0; baud_div = 16'd3; rxd = 1'b1;
        m_ready = 1'b0; flush = 1'b0; clr_ovr = 1'b0;
        set_fmt(2'b11, 2'b00, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {m_valid, m_data, m_perr, m_ferr, m_brk, overrun, busy}, '0);
        chk("reset_level", fifo_level, 4'd0);
        rx_en = 1'b1;
        idle_bits(2);

        // 8N1 0xA5 with push-to-visible latency
        lat = 0;
        fork
            send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            begin
                int n;
                n = 0;
                while (rxd && n < 200) begin @(negedge clk); n++; end
                n = 0;
                while (!m_valid && n < 1000) begin @(negedge clk); n++; end
                lat = n;
                chk("a5_busy_low_at_valid", busy, 1'b0);
            end
        join
        chk("a5_latency_window", (lat >= 614 && lat <= 628), 1'b1);
        idle_bits(1);
        chk("a5_level", fifo_level, 4'd1);
        pop_check("a5_entry", 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("a5_empty_after_pop", m_valid, 1'b0);

        // 7E2 0x35 (four ones): wrong parity then right parity
        set_fmt(2'b10, 2'b01, 1'b1);
        send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle_bits(1);
        pop_check("7e2_bad_parity", 8'h35, 1'b1, 1'b0, 1'b0);
        send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle_bits(1);
        pop_check("7e2_good_parity", 8'h35, 1'b0, 1'b0, 1'b0);

        // 5O1 0x1F with low stop bit, line stays low, then 0x0A
        set_fmt(2'b00, 2'b10, 1'b0);
        send_frame(8'h1F, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("5o1_wait_high_busy", busy, 1'b1);
        chk("5o1_pushed_while_low", m_valid, 1'b1);
        idle_bits(1);
        chk("5o1_idle_after_high", busy, 1'b0);
        pop_check("5o1_ferr_entry", 8'h1F, 1'b0, 1'b1, 1'b0);
        send_frame(8'h0A, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle_bits(1);
        pop_check("5o1_next_frame", 8'h0A, 1'b0, 1'b0, 1'b0);

        // 8N1 line held low for 30 bit times: one break entry only
        set_fmt(2'b11, 2'b00, 1'b0);
        for (int i = 0; i < 30; i++) drive_bit(1'b0, 1'b0);
        chk("brk_single_entry", fifo_level, 4'd1);
        chk("brk_held_busy", busy, 1'b1);
        idle_bits(2);
        chk("brk_no_more_entries", fifo_level, 4'd1);
        wait_not_busy("brk_idle");
        pop_check("brk_entry", 8'h00, 1'b0, 1'b1, 1'b1);

        // Short low glitch in IDLE: false start
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            rxd = 1'b0;
        end
        @(negedge clk);
        rxd = 1'b1;
        chk("glitch_start_seen", busy, 1'b1);
        idle_bits(2);
        chk("glitch_idle", busy, 1'b0);
        chk("glitch_no_entry", fifo_level, 4'd0);

        // One corrupted vote sample per data bit
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle_bits(1);
        pop_check("majority_vote", 8'hC3, 1'b0, 1'b0, 1'b0);

        // rx_en dropped mid-frame: frame discarded
        fork
            send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            begin
                repeat (4*BIT_CYC) @(negedge clk);
                rx_en = 1'b0;
                @(negedge clk);
                chk("rxen_abort_busy", busy, 1'b0);
            end
        join
        idle_bits(1);
        chk("rxen_abort_no_entry", fifo_level, 4'd0);
        rx_en = 1'b1;
        idle_bits(1);

        // Nine frames into an 8-deep FIFO with no consumer
        for (int i = 0; i < 9; i++) send_frame(ovr_vals[i], 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_bits(1);
        chk("ovr_level_full", fifo_level, 4'd8);
        chk("ovr_flag_set", overrun, 1'b1);
        for (int i = 0; i < 8; i++) pop_check($sformatf("ovr_pop_%0d", i), ovr_vals[i], 1'b0, 1'b0, 1'b0);
        chk("ovr_drained", {m_valid, fifo_level}, 5'd0);
        chk("ovr_sticky", overrun, 1'b1);
        @(negedge clk);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        chk("ovr_cleared", overrun, 1'b0);

        // Flush in the middle of a stream
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("flush_pre_level", fifo_level, 4'd2);
        pulse_flush();
        chk("flush_empty", {m_valid, fifo_level}, 5'd0);
        send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_bits(1);
        chk("flush_post_level", fifo_level, 4'd1);
        pop_check("flush_post_entry", 8'h7E, 1'b0, 1'b0, 1'b0);
        chk("final_overrun", overrun, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
